// File: rtl/genius_param_seq.sv
// Parametrised sequence-memory game controller: plays back a growing one-hot
// sequence on the LEDs, then checks the player's presses against it round by round.
module genius_param_seq #(
  parameter int unsigned N_BOTOES       = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DEMO_RODADAS   = 4,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned LED_CICLOS     = 500
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      jogar,
  input  logic [N_BOTOES-1:0]       botoes,
  input  logic                      modo,
  output logic                      ganhou,
  output logic                      perdeu,
  output logic                      timeout,
  output logic                      pronto,
  output logic [N_BOTOES-1:0]       leds,
  output logic [3:0]                db_estado,
  output logic [$clog2(DEPTH)-1:0]  db_rodada,
  output logic [$clog2(DEPTH)-1:0]  db_jogada,
  output logic                      db_modo
);

  localparam int unsigned RW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int unsigned LW = $clog2(LED_CICLOS + 1);

  localparam logic [RW-1:0] ULT_NORMAL = RW'(DEPTH - 1);
  localparam logic [RW-1:0] ULT_DEMO   = RW'(DEMO_RODADAS - 1);
  localparam logic [TW-1:0] TMO_FIM    = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [LW-1:0] LED_FIM    = LW'(LED_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA      = 4'd2,
    INTERVALO   = 4'd3,
    ESPERA      = 4'd4,
    COMPARA     = 4'd5,
    PROX_JOGADA = 4'd6,
    PROX_RODADA = 4'd7,
    FIM_GANHOU  = 4'd8,
    FIM_PERDEU  = 4'd9,
    FIM_TIMEOUT = 4'd10
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [RW-1:0]         rodada_q, rodada_d;
  logic [RW-1:0]         jogada_q, jogada_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [LW-1:0]         led_q, led_d;
  logic                  modo_q, modo_d;
  logic [N_BOTOES-1:0]   jogada_reg_q;
  logic                  press_q;

  logic                  press;
  logic                  evento;
  logic [N_BOTOES-1:0]   item;
  logic                  acerto;
  logic                  tmo_fim;
  logic                  led_fim;
  logic                  ultima;

  // Item k lights button (k mod N_BOTOES); derived from the index, no storage.
  function automatic logic [N_BOTOES-1:0] item_de(input logic [RW-1:0] k);
    int unsigned ki;
    ki = 32'(k) % N_BOTOES;
    return N_BOTOES'(1) << ki;
  endfunction

  always_comb begin
    press   = |botoes;
    evento  = press & ~press_q;
    item    = item_de(jogada_q);
    acerto  = (jogada_reg_q == item);
    tmo_fim = (tmo_q == TMO_FIM);
    led_fim = (led_q == LED_FIM);
    ultima  = (rodada_q == (modo_q ? ULT_DEMO : ULT_NORMAL));
  end

  always_comb begin
    estado_d = estado_q;
    rodada_d = rodada_q;
    jogada_d = jogada_q;
    tmo_d    = '0;
    led_d    = '0;
    modo_d   = modo_q;
    leds     = '0;

    case (estado_q)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
        if (jogar) begin
          estado_d = PREPARA;
          rodada_d = '0;
          jogada_d = '0;
        end
      end
      PREPARA: begin
        modo_d   = modo;
        rodada_d = '0;
        jogada_d = '0;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        leds = item;
        if (led_fim) estado_d = INTERVALO;
        else         led_d    = led_q + 1'b1;
      end
      INTERVALO: begin
        if (!led_fim) begin
          led_d = led_q + 1'b1;
        end else if (jogada_q == rodada_q) begin
          jogada_d = '0;
          estado_d = ESPERA;
        end else begin
          jogada_d = jogada_q + 1'b1;
          estado_d = MOSTRA;
        end
      end
      ESPERA: begin
        leds = botoes;
        // A press on the last allowed cycle still counts.
        if (evento)       estado_d = COMPARA;
        else if (tmo_fim) estado_d = FIM_TIMEOUT;
        else              tmo_d    = tmo_q + 1'b1;
      end
      COMPARA: begin
        if (!acerto)                   estado_d = FIM_PERDEU;
        else if (jogada_q < rodada_q)  estado_d = PROX_JOGADA;
        else if (ultima)               estado_d = FIM_GANHOU;
        else                           estado_d = PROX_RODADA;
      end
      PROX_JOGADA: begin
        jogada_d = jogada_q + 1'b1;
        estado_d = ESPERA;
      end
      PROX_RODADA: begin
        rodada_d = rodada_q + 1'b1;
        jogada_d = '0;
        estado_d = MOSTRA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      rodada_q     <= '0;
      jogada_q     <= '0;
      tmo_q        <= '0;
      led_q        <= '0;
      modo_q       <= 1'b0;
      jogada_reg_q <= '0;
      press_q      <= 1'b0;
    end else begin
      estado_q <= estado_d;
      rodada_q <= rodada_d;
      jogada_q <= jogada_d;
      tmo_q    <= tmo_d;
      led_q    <= led_d;
      modo_q   <= modo_d;
      press_q  <= press;
      if (evento) jogada_reg_q <= botoes;
    end
  end

  always_comb begin
    ganhou    = (estado_q == FIM_GANHOU);
    perdeu    = (estado_q == FIM_PERDEU);
    timeout   = (estado_q == FIM_TIMEOUT);
    pronto    = ganhou | perdeu | timeout;
    db_estado = estado_q;
    db_rodada = rodada_q;
    db_jogada = jogada_q;
    db_modo   = modo_q;
  end

endmodule
